// File: rtl/blink_pkg.sv
// Shared widths and debouncer state encoding for the blink tick generator.
package blink_pkg;
  localparam int CNT_W  = 26;
  localparam int RATE_W = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } deb_state_t;
endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, and a
// one-cycle press event on the accepted press edge.
module key_debounce
  import blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic KEY,
  output logic press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic key_s1, key_s2;
  deb_state_t state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= KEY;
      key_s2 <= key_s1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  // press decodes registered state only, so it is a clean synchronous enable
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (key_s2) begin
          state_nxt = WAIT_PRESS;
          dcnt_nxt  = '0;
        end
      end
      WAIT_PRESS: begin
        if (!key_s2) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else if (dcnt == LAST) begin
          state_nxt = PRESSED;
          dcnt_nxt  = '0;
          press     = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_s2) begin
          state_nxt = WAIT_RELEASE;
          dcnt_nxt  = '0;
        end
      end
      WAIT_RELEASE: begin
        if (key_s2) begin
          state_nxt = PRESSED;
          dcnt_nxt  = '0;
        end else if (dcnt == LAST) begin
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dcnt_nxt  = '0;
      end
    endcase
  end
endmodule

// File: rtl/blink_tick_gen.sv
// LED blink tick generator: period BASE_PERIOD << rate_sel, rate stepped by a
// debounced KEY press. Optional BLINK_PAUSE_EN adds a pause input.
module blink_tick_gen
  import blink_pkg::*;
#(
  parameter int BASE_PERIOD     = 5000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              KEY,
`ifdef BLINK_PAUSE_EN
  input  logic              pause,
`endif
  output logic              tick,
  output logic [RATE_W-1:0] rate_sel
);
  localparam logic [CNT_W-1:0] BASE = CNT_W'(BASE_PERIOD);

  logic             press;
  logic             run;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .KEY     (KEY),
    .press   (press)
  );

`ifdef BLINK_PAUSE_EN
  assign run = !pause;
`else
  assign run = 1'b1;
`endif

  assign term = (BASE << rate_sel) - 1'b1;

  // A rate change takes priority over the terminal count: counter clears, no tick.
  // BASE_PERIOD must be >= 2 so tick can never stay high two cycles running.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      tick     <= 1'b0;
      rate_sel <= '0;
    end else begin
      tick <= 1'b0;
      if (press) begin
        rate_sel <= rate_sel + 1'b1;
        cnt      <= '0;
      end else if (run) begin
        if (cnt == term) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
